// File: rtl/teatris_detector_jogada_if.sv
// teatris_detector_jogada_if: button and control-unit signals of the TEAtris play detector
interface teatris_detector_jogada_if #(
  parameter int N_BOTOES = 4
);
  logic [N_BOTOES-1:0] botoes;
  logic                registra_jogada;
  logic                zera_jogada;
  logic                tem_jogada;
  logic [N_BOTOES-1:0] jogada;
  logic [1:0]          db_estado;
  modport master (
    output botoes, registra_jogada, zera_jogada,
    input  tem_jogada, jogada, db_estado
  );
  modport slave (
    input  botoes, registra_jogada, zera_jogada,
    output tem_jogada, jogada, db_estado
  );
endinterface

// File: rtl/teatris_detector_jogada.sv
// teatris_detector_jogada: synchronises and debounces player buttons, one pulse per accepted press
module teatris_detector_jogada #(
  parameter int N_BOTOES = 4,
  parameter int DEBOUNCE = 50000
) (
  input logic                         clock,
  input logic                         reset,
  teatris_detector_jogada_if.slave    bus
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  typedef enum logic [1:0] {
    OCIOSO        = 2'b00,
    FILTRA        = 2'b01,
    PULSO         = 2'b10,
    ESPERA_SOLTAR = 2'b11
  } estado_t;
  estado_t             r_estado;
  logic [N_BOTOES-1:0] r_sync1;
  logic [N_BOTOES-1:0] r_sync2;
  logic [N_BOTOES-1:0] r_cand;
  logic [N_BOTOES-1:0] r_jog;
  logic [CW-1:0]       r_cont;
  logic                r_tem;
  logic                w_one_hot;
  logic                w_fim;
  assign w_one_hot = (r_sync2 != '0) && ((r_sync2 & (r_sync2 - 1'b1)) == '0);
  assign w_fim     = r_cont == CW'(DEBOUNCE - 1);
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.botoes;
      r_sync2 <= r_sync1;
    end
  end
  // r_tem is raised together with the move into PULSO so it is high exactly while in PULSO
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= OCIOSO;
      r_cand   <= '0;
      r_cont   <= '0;
      r_tem    <= 1'b0;
    end else begin
      r_tem <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (w_one_hot) begin
            r_cand   <= r_sync2;
            r_cont   <= '0;
            r_estado <= FILTRA;
          end
        end
        FILTRA: begin
          if (r_sync2 != r_cand) begin
            r_cont   <= '0;
            r_estado <= OCIOSO;
          end else if (w_fim) begin
            r_tem    <= 1'b1;
            r_estado <= PULSO;
          end else begin
            r_cont <= r_cont + 1'b1;
          end
        end
        PULSO: begin
          r_cont   <= '0;
          r_estado <= ESPERA_SOLTAR;
        end
        ESPERA_SOLTAR: begin
          if (r_sync2 != '0) r_cont <= '0;
          else if (w_fim) r_estado <= OCIOSO;
          else r_cont <= r_cont + 1'b1;
        end
        default: r_estado <= OCIOSO;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) r_jog <= '0;
    else r_jog <= bus.zera_jogada ? '0 : bus.registra_jogada ? r_cand : r_jog;
  end
  assign bus.tem_jogada = r_tem;
  assign bus.jogada     = r_jog;
  assign bus.db_estado  = r_estado;
endmodule

// File: tb/tb_teatris_detector_jogada.sv
// tb_teatris_detector_jogada: table, scenario and random checks of the play detector
module tb_teatris_detector_jogada;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  teatris_detector_jogada_if #(.N_BOTOES(4)) bus ();
  teatris_detector_jogada #(.N_BOTOES(4), .DEBOUNCE(D)) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus)
  );
  int errors = 0;
  int checks = 0;
  int cyc_n = 0;
  int npulse = 0;
  int last_pulse = -1;
  logic       obs_tem;
  logic [3:0] obs_jog;
  logic [1:0] obs_est;
  // reference: two-sample delay, then run-length rules on the synchronised samples
  logic [3:0] m_s1, m_s2, m_cand, m_jog;
  bit m_pulse, m_armed, m_valid = 0;
  int m_k, m_quiet;
  typedef struct {
    logic [3:0] b;
    logic       rg;
    logic       zr;
    logic       tem;
    logic [3:0] jog;
    logic [1:0] est;
  } vec_t;
  vec_t tbl[14];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask
  task automatic cyc(input logic [3:0] raw, input logic rg, input logic zr, input logic r);
    logic [3:0] s;
    bus.botoes = raw;
    bus.registra_jogada = rg;
    bus.zera_jogada = zr;
    rst = r;
    @(negedge clk);
    obs_tem = bus.tem_jogada;
    obs_jog = bus.jogada;
    obs_est = bus.db_estado;
    if (obs_tem === 1'b1) begin
      npulse++;
      last_pulse = cyc_n;
    end
    if (m_valid) begin
      chk("model_tem", int'(obs_tem), int'(m_pulse));
      chk("model_jog", int'(obs_jog), int'(m_jog));
      chk("model_pulse_state", int'(obs_est == 2'b10), int'(m_pulse));
    end
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_cand = 0; m_jog = 0;
      m_pulse = 0; m_armed = 1; m_k = 0; m_quiet = 0; m_valid = 1;
    end else begin
      s = m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
      m_jog = zr ? 4'h0 : (rg ? m_cand : m_jog);
      if (m_pulse) begin
        m_pulse = 0; m_armed = 0; m_quiet = 0;
      end else if (m_armed) begin
        if (m_k == 0) begin
          if ($countones(s) == 1) begin m_cand = s; m_k = 1; end
        end else if (s != m_cand) m_k = 0;
        else begin
          m_k++;
          if (m_k == D + 1) begin m_pulse = 1; m_k = 0; end
        end
      end else begin
        m_quiet = (s != 0) ? 0 : m_quiet + 1;
        if (m_quiet == D) begin m_armed = 1; m_k = 0; end
      end
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask
  task automatic run(input logic [3:0] raw, input int n);
    for (int i = 0; i < n; i++) cyc(raw, 1'b0, 1'b0, 1'b0);
  endtask
  function automatic logic [3:0] pick();
    case ($urandom_range(0, 3))
      0: return 4'h0;
      3: return 4'($urandom);
      default: return 4'(1 << $urandom_range(0, 3));
    endcase
  endfunction
  int p0, t0;
  logic [3:0] rraw;
  initial begin
    for (int i = 0; i < 14; i++) begin
      tbl[i].b = 4'b0100; tbl[i].rg = 0; tbl[i].zr = 0;
      tbl[i].tem = (i == 7);
      tbl[i].jog = (i >= 9 && i <= 12) ? 4'b0100 : 4'b0000;
      tbl[i].est = (i < 3) ? 2'b00 : (i < 7) ? 2'b01 : (i == 7) ? 2'b10 : 2'b11;
    end
    tbl[8].rg = 1;
    tbl[12].rg = 1;
    tbl[12].zr = 1;
    rst = 1'b1;
    bus.botoes = 4'hf;
    bus.registra_jogada = 0;
    bus.zera_jogada = 0;
    @(posedge clk);
    #1;
    cyc(4'hf, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      cyc(4'hf, 0, 0, 1);
      chk("reset_tem", int'(obs_tem), 0);
      chk("reset_jog", int'(obs_jog), 0);
      chk("reset_est", int'(obs_est), 0);
    end
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].b, tbl[i].rg, tbl[i].zr, 1'b0);
      chk($sformatf("tbl%0d_tem", i), int'(obs_tem), int'(tbl[i].tem));
      chk($sformatf("tbl%0d_jog", i), int'(obs_jog), int'(tbl[i].jog));
      chk($sformatf("tbl%0d_est", i), int'(obs_est), int'(tbl[i].est));
    end
    run(0, 10);
    p0 = npulse; t0 = cyc_n;
    run(4'b0100, 2); run(0, 1); run(4'b0100, 12);
    chk("bounce_count", npulse - p0, 1);
    chk("bounce_cycle", last_pulse - t0, 10);
    run(0, 10);
    p0 = npulse;
    run(4'b0101, 20);
    chk("multi_none", npulse - p0, 0);
    t0 = cyc_n;
    run(4'b0100, 10);
    chk("multi_then_single", npulse - p0, 1);
    chk("multi_then_single_cycle", last_pulse - t0, 7);
    run(0, 10);
    p0 = npulse;
    run(4'b0010, 100);
    chk("long_hold", npulse - p0, 1);
    run(0, 2); run(4'b0010, 10);
    chk("short_release", npulse - p0, 1);
    run(0, 10);
    t0 = cyc_n;
    run(4'b0010, 10);
    chk("second_press", npulse - p0, 2);
    chk("second_press_cycle", last_pulse - t0, 7);
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    chk("registra_jog", int'(obs_jog), 2);
    cyc(0, 1, 1, 0); cyc(0, 0, 0, 0);
    chk("zera_priority", int'(obs_jog), 0);
    run(0, 10);
    p0 = npulse; t0 = cyc_n;
    run(4'b0100, 5); cyc(4'b0100, 0, 0, 1); run(4'b0100, 2);
    chk("reset_mid_filtra", npulse - p0, 0);
    run(4'b0100, 10);
    chk("requalify_count", npulse - p0, 1);
    chk("requalify_cycle", last_pulse - t0, 13);
    rraw = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rraw = pick();
      cyc(rraw, $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 199) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
